// File: rtl/lock_pkg.sv
// lock_pkg: keypad bit positions, internal key codes, command encodings and sequencer states
package lock_pkg;
    localparam int KEY_ENTER_BIT  = 9;
    localparam int KEY_ZERO_BIT   = 10;
    localparam int KEY_CHANGE_BIT = 11;
    localparam logic [3:0] CODE_ENTER  = 4'hA;
    localparam logic [3:0] CODE_CHANGE = 4'hB;
    localparam logic [3:0] CODE_NONE   = 4'hF;
    localparam logic CMD_ENTER  = 1'b0;
    localparam logic CMD_CHANGE = 1'b1;
    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;
    // Map a one-hot keypad word to a digit value, CODE_ENTER or CODE_CHANGE; anything else is CODE_NONE
    function automatic logic [3:0] key_decode(input logic [11:0] k);
        logic [3:0] c;
        c = CODE_NONE;
        for (int i = 0; i < 9; i++) if (k[i]) c = 4'(i + 1);
        if (k[KEY_ZERO_BIT]) c = 4'd0;
        if (k[KEY_ENTER_BIT]) c = CODE_ENTER;
        if (k[KEY_CHANGE_BIT]) c = CODE_CHANGE;
        return $onehot(k) ? c : CODE_NONE;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: accepts a keypad press once after it has been steady, and re-arms only after a steady release
module key_debounce
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] key,
    output logic [3:0]  key_code,
    output logic        key_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
    logic [3:0] cur, prev;
    logic [CW-1:0] cnt, cnt_n;
    logic armed, stable;
    assign cur = key_decode(key);
    assign cnt_n = (cur != prev) ? CW'(1) : (cnt == DMAX) ? DMAX : cnt + 1'b1;
    assign stable = (cnt_n == DMAX) && !((cur == prev) && (cnt == DMAX));
    assign key_code = prev;
    // Count consecutive identical samples; a steady key fires once when armed, a steady "no key" re-arms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= CODE_NONE;
            cnt     <= '0;
            armed   <= 1'b1;
            key_evt <= 1'b0;
        end else begin
            prev    <= cur;
            cnt     <= cnt_n;
            key_evt <= stable && armed && (cur != CODE_NONE);
            if (stable) armed <= (cur == CODE_NONE);
        end
    end
endmodule

// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: collects four keypad digits and issues ENTER/CHANGE commands; KEYSEQ_TIMEOUT_EN adds an inactivity timeout
module key_entry_sequencer
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] key,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_type,
    output logic [15:0] cmd_data,
    output logic [2:0]  digit_cnt,
    output logic        busy,
    output logic        err,
    output logic        timeout
);
    state_t state, state_n;
    logic [15:0] buffer, buffer_n;
    logic [2:0] cnt_n;
    logic [3:0] key_code;
    logic type_n, key_evt, is_digit, full, expired;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .key_code (key_code),
        .key_evt  (key_evt)
    );
    assign is_digit  = key_code <= 4'd9;
    assign full      = digit_cnt == 3'd4;
    assign cmd_valid = state == ISSUE;
    assign busy      = state != IDLE;
    assign cmd_data  = buffer;
`ifdef KEYSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic reload;
    assign reload  = key_evt && (state == COLLECT || (state == IDLE && is_digit));
    assign expired = (state == COLLECT) && (timer == '0);
    // Inactivity countdown, restarted on entry to COLLECT and on every accepted key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else if (reload) timer <= TW'(TIMEOUT_CYCLES - 1);
        else if (state == COLLECT && timer != '0) timer <= timer - 1'b1;
    end
`else
    assign expired = TIMEOUT_CYCLES < 0;
`endif
    // Next-state and datapath decisions; an accepted key always wins over a simultaneous expiry
    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        cnt_n    = digit_cnt;
        type_n   = cmd_type;
        err      = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: if (key_evt) begin
                err = !is_digit;
                if (is_digit) begin
                    buffer_n = {12'h000, key_code};
                    cnt_n    = 3'd1;
                    state_n  = COLLECT;
                end
            end
            COLLECT: if (key_evt && is_digit) begin
                err = full;
                if (!full) begin
                    buffer_n = {buffer[11:0], key_code};
                    cnt_n    = digit_cnt + 3'd1;
                end
            end else if (key_evt && full) begin
                type_n  = (key_code == CODE_CHANGE) ? CMD_CHANGE : CMD_ENTER;
                state_n = ISSUE;
            end else if (key_evt || expired) begin
                err      = key_evt;
                timeout  = !key_evt;
                buffer_n = '0;
                cnt_n    = '0;
                state_n  = IDLE;
            end
            ISSUE: if (cmd_ready) begin
                buffer_n = '0;
                cnt_n    = '0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // State, digit buffer, digit count and command type registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buffer    <= '0;
            digit_cnt <= '0;
            cmd_type  <= CMD_ENTER;
        end else begin
            state     <= state_n;
            buffer    <= buffer_n;
            digit_cnt <= cnt_n;
            cmd_type  <= type_n;
        end
    end
endmodule

// File: tb/tb_key_entry_sequencer.sv
// tb_key_entry_sequencer: directed and randomized key sequences checked against a press-level reference model
module tb_key_entry_sequencer;
    localparam int D = 4;
    localparam int T = 1000;
    logic clk = 1'b0, rst_n = 1'b0, cmd_ready = 1'b0;
    logic [11:0] key = '0;
    logic cmd_valid, cmd_type, busy, err, timeout;
    logic [15:0] cmd_data;
    logic [2:0] digit_cnt;
    int checks = 0, errors = 0, err_pulses = 0, to_pulses = 0;
    int m_state = 0;
    int m_digits[$];
    bit m_type = 1'b0;
    int m_err = 0;

    key_entry_sequencer #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .err       (err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err) err_pulses++;
        if (timeout) to_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] kbits(input int code);
        logic [11:0] k;
        k = '0;
        if (code == 10) k[9] = 1'b1;
        else if (code == 11) k[11] = 1'b1;
        else if (code == 0) k[10] = 1'b1;
        else k[code-1] = 1'b1;
        return k;
    endfunction

    function automatic logic [15:0] m_data();
        logic [15:0] d;
        d = '0;
        foreach (m_digits[i]) d = 16'(d * 16 + m_digits[i]);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_press(input int code);
        if (m_state == 2) return;
        if (code <= 9) begin
            if (m_state == 0) begin
                m_digits = {code};
                m_state = 1;
            end else if (m_digits.size() < 4) m_digits.push_back(code);
            else m_err++;
        end else if (m_state == 1 && m_digits.size() == 4) begin
            m_type = (code == 11);
            m_state = 2;
        end else begin
            m_err++;
            m_digits.delete();
            m_state = 0;
        end
    endtask

    task automatic drive(input logic [11:0] k, input int hold, input int rel, input int code);
        key = k;
        repeat (hold) @(negedge clk);
        key = '0;
        repeat (rel) @(negedge clk);
        if (hold >= D && code >= 0) model_press(code);
    endtask

    task automatic press(input int code, input int hold = 10, input int rel = 10);
        drive(kbits(code), hold, rel, code);
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.cnt", tag), 32'(digit_cnt), m_digits.size());
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(m_state != 0));
        chk($sformatf("%s.valid", tag), 32'(cmd_valid), 32'(m_state == 2));
        chk($sformatf("%s.data", tag), 32'(cmd_data), 32'(m_data()));
        chk($sformatf("%s.err", tag), err_pulses, m_err);
        if (m_state == 2) chk($sformatf("%s.type", tag), 32'(cmd_type), 32'(m_type));
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        if (m_state == 2) begin
            m_state = 0;
            m_digits.delete();
        end
        check_all(tag);
    endtask

    initial begin
        int code, hold, rel;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(cmd_valid), 0);
        chk("rst.type", 32'(cmd_type), 0);
        chk("rst.data", 32'(cmd_data), 0);
        chk("rst.cnt", 32'(digit_cnt), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (m_digits[i]) m_digits.delete();
        press(2); press(4); press(3); press(3);
        check_all("enter4");
        press(10);
        check_all("enter_issue");
        chk("enter_data", 32'(cmd_data), 32'h2433);
        handshake("enter_hs");

        press(1); press(4); press(3); press(3); press(11);
        check_all("change_issue");
        chk("change_data", 32'(cmd_data), 32'h1433);
        press(5, 6, 6);
        check_all("change_wait");
        repeat (8) @(negedge clk);
        check_all("change_wait2");
        handshake("change_hs");

        press(2, 3, 5); press(2, 3, 5);
        check_all("bounce");
        drive(12'h003, 10, 10, -1);
        check_all("multihot");

        press(2); press(4); press(3); press(10);
        check_all("short_enter");
        press(1); press(2); press(3); press(4); press(5);
        check_all("fifth_digit");
        press(10);
        chk("fifth_data", 32'(cmd_data), 32'h1234);
        handshake("fifth_hs");

        press(7);
`ifdef KEYSEQ_TIMEOUT_EN
        repeat (T - 40) @(negedge clk);
        check_all("pre_timeout");
        repeat (60) @(negedge clk);
        m_state = 0;
        m_digits.delete();
        chk("timeout_pulses", to_pulses, 1);
        check_all("post_timeout");
`else
        repeat (5000) @(negedge clk);
        chk("no_timeout", to_pulses, 0);
        check_all("wait_forever");
        press(10);
        check_all("wait_abort");
`endif

        press(9); press(9); press(9); press(9); press(10);
        check_all("pre_reset");
        key = kbits(9);
        #2 rst_n = 1'b0;
        #1;
        m_state = 0;
        m_digits.delete();
        chk("async_rst.valid", 32'(cmd_valid), 0);
        chk("async_rst.busy", 32'(busy), 0);
        chk("async_rst.data", 32'(cmd_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        key = '0;
        repeat (8) @(negedge clk);
        check_all("held_through_reset");
        press(9); press(9); press(9); press(9); press(10);
        check_all("post_reset_issue");
        chk("post_reset_data", 32'(cmd_data), 32'h9999);
        handshake("post_reset_hs");

        for (int n = 0; n < 60; n++) begin
            if (m_state == 1 && m_digits.size() == 4 && $urandom_range(0, 1) == 1)
                code = 10 + int'($urandom_range(0, 1));
            else
                code = int'($urandom_range(0, 11));
            hold = int'($urandom_range(1, 12));
            rel = int'($urandom_range(D, 10));
            if ($urandom_range(0, 7) == 0) drive(kbits(code) | kbits((code + 1) % 12), hold, rel, -1);
            else press(code, hold, rel);
            check_all($sformatf("rnd%0d", n));
            if (m_state == 2 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 7) == 0)
                handshake($sformatf("rnd_hs%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_entry_sequencer.md
KEY_ENTRY_SEQUENCER -- requirements
Module: key_entry_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a key press or release is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before the entry is abandoned.
REQ-003 clock  in  1  single clock; all flops rise-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Key  in  12  one-hot keypad: bits 0-8 = digits 1-9, bit 10 = digit 0, bit 9 = ENTER, bit 11 = CHANGE.
REQ-006 cmd_valid  out  1  command to lock core pending.
REQ-007 cmd_ready  in  1  lock core accepts command.
REQ-008 cmd_type  out  1  0 = ENTER (verify code), 1 = CHANGE (set new code).
REQ-009 cmd_data  out  16  four BCD digits; first-entered digit in [15:12].
REQ-010 digit_cnt  out  3  digits currently buffered, 0-4.
REQ-011 busy  out  1  high in COLLECT or ISSUE.
REQ-012 err  out  1  one-cycle pulse on a rejected key sequence.
REQ-013 timeout  out  1  one-cycle pulse when an entry is abandoned for inactivity.

Function
REQ-014 Key values with zero or more than one bit set SHALL be treated as "no key".
REQ-015 A press SHALL be accepted once, after one valid Key value has been stable for DEBOUNCE_CYCLES cycles; the next press requires "no key" stable for DEBOUNCE_CYCLES cycles.
REQ-016 A value change before the count completes SHALL restart the debounce count.
REQ-017 States SHALL be IDLE, COLLECT, ISSUE.
REQ-018 IDLE: an accepted digit SHALL be loaded into [3:0], set digit_cnt=1, and go to COLLECT; ENTER or CHANGE SHALL pulse err and stay in IDLE.
REQ-019 COLLECT: an accepted digit with digit_cnt<4 SHALL shift the buffer left 4 bits, insert the digit at [3:0], and increment digit_cnt.
REQ-020 COLLECT: a digit with digit_cnt=4 SHALL be discarded and pulse err; the buffer is unchanged.
REQ-021 COLLECT: ENTER or CHANGE with digit_cnt=4 SHALL set cmd_type accordingly and go to ISSUE the next cycle.
REQ-022 COLLECT: ENTER or CHANGE with digit_cnt<4 SHALL pulse err, clear the buffer and digit_cnt, and return to IDLE.
REQ-023 ISSUE: cmd_valid SHALL be high, with cmd_type and cmd_data stable until cmd_valid&cmd_ready.
REQ-024 ISSUE: keys SHALL be ignored, but debounce tracking continues.
REQ-025 On the handshake cycle the buffer and digit_cnt SHALL clear and the state SHALL return to IDLE; cmd_valid is low the next cycle.
REQ-026 cmd_ready while not in ISSUE SHALL have no effect.
REQ-027 A key acceptance in the same cycle as a timeout expiry SHALL take priority: it is processed and the timer reloads.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, with cmd_valid=0, cmd_type=0, cmd_data=0, digit_cnt=0, busy=0, err=0, timeout=0, and debounce/timer counters cleared.
REQ-029 Reset asserted during ISSUE SHALL drop cmd_valid immediately, with no handshake.
REQ-030 After reset deassertion, a Key held throughout reset SHALL require a full debounce before acceptance.

Configuration
REQ-031 With KEYSEQ_TIMEOUT_EN defined: a TIMEOUT_CYCLES counter SHALL reload on entry to COLLECT and on each accepted key.
REQ-032 With KEYSEQ_TIMEOUT_EN defined: on expiry, the block SHALL pulse timeout, clear the buffer, and return to IDLE.
REQ-033 With KEYSEQ_TIMEOUT_EN undefined: no timer SHALL exist, timeout SHALL be tied 0, and COLLECT waits indefinitely.

Structure
REQ-034 Shared package lock_pkg SHALL hold the Key bit-position constants, cmd_type encodings (CMD_ENTER=0, CMD_CHANGE=1) and the state enum.
REQ-035 Debounce SHALL be a sub-module key_debounce (Key in; key_code[3:0] and key_evt pulse out).
REQ-036 RTL target: 120-400 lines total.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000)
REQ-037 Keys 2,4,3,3 then ENTER, each held 10 cycles with 10 release cycles -> cmd_valid=1, cmd_type=0, cmd_data=16'h2433; cleared one cycle after cmd_ready.
REQ-038 Keys 1,4,3,3 then CHANGE, with cmd_ready held low 20 cycles -> cmd_data=16'h1433 and cmd_type=1 stable throughout; a key 5 pressed during the wait is ignored.
REQ-039 Key 2 held 3 cycles, released, repeated -> no digit accepted; Key 12'h003 (multi-hot) held 10 cycles -> ignored, digit_cnt stays 0.
REQ-040 Keys 2,4,3 then ENTER -> err pulse, digit_cnt=0, IDLE; keys 1,2,3,4,5 -> err pulse on 5, cmd_data after ENTER = 16'h1234.
REQ-041 With KEYSEQ_TIMEOUT_EN: key 7 then 1000 idle cycles -> timeout pulse, digit_cnt=0; without the macro, digit_cnt stays 1 after 5000 cycles.
REQ-042 reset low mid-ISSUE -> cmd_valid=0 asynchronously; after release, keys 9,9,9,9 and ENTER -> cmd_data=16'h9999.
